// File: rtl/axi_ram_slave.sv
// AXI4 INCR-burst slave backed by a dual-port word RAM split into four byte lanes.
// Write (AW/W/B) and read (AR/R) engines run independently and share only the RAM.
module axi_ram_slave #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        S_AXI_AWID,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic [7:0]  S_AXI_AWLEN,
   input  logic [2:0]  S_AXI_AWSIZE,
   input  logic [1:0]  S_AXI_AWBURST,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WLAST,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic        S_AXI_BID,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic        S_AXI_ARID,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic [7:0]  S_AXI_ARLEN,
   input  logic [2:0]  S_AXI_ARSIZE,
   input  logic [1:0]  S_AXI_ARBURST,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic        S_AXI_RID,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RLAST,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY
);
   localparam int IDX_W = ADDR_WIDTH - 2;
   localparam int DEPTH = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] IDX_ONE = 1;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   w_state_t         w_state_reg;
   logic [IDX_W-1:0] w_idx_reg;
   logic [7:0]       w_len_reg, w_cnt_reg;
   logic             w_err_reg, w_id_reg;
   logic             awready_reg, wready_reg, bvalid_reg;
   logic [1:0]       bresp_reg;

   r_state_t         r_state_reg;
   logic [IDX_W-1:0] r_idx_reg;
   logic [7:0]       r_len_reg, r_cnt_reg;
   logic             r_id_reg, rlast_reg, arready_reg, rvalid_reg;
   logic [1:0]       rresp_reg;

   logic             w_hs, w_last_beat;
   logic [31:0]      rdata_w;
   logic             unused_addr_bits;

   assign unused_addr_bits = ^{S_AXI_AWADDR[31:ADDR_WIDTH], S_AXI_AWADDR[1:0],
                               S_AXI_ARADDR[31:ADDR_WIDTH], S_AXI_ARADDR[1:0]};

   // wready_reg is only ever high in W_DATA, so this alone marks a RAM write beat
   assign w_hs        = S_AXI_WVALID && wready_reg && !RST;
   assign w_last_beat = (w_cnt_reg == w_len_reg);

   always_ff @(posedge CLK) begin
      if (RST) begin
         w_state_reg <= W_IDLE;
         awready_reg <= 1'b0;
         wready_reg  <= 1'b0;
         bvalid_reg  <= 1'b0;
         bresp_reg   <= 2'b00;
         w_id_reg    <= 1'b0;
         w_idx_reg   <= '0;
         w_len_reg   <= 8'd0;
         w_cnt_reg   <= 8'd0;
         w_err_reg   <= 1'b0;
      end else begin
         case (w_state_reg)
            W_IDLE: begin
               awready_reg <= 1'b1;
               if (S_AXI_AWVALID && awready_reg) begin
                  awready_reg <= 1'b0;
                  wready_reg  <= 1'b1;
                  w_id_reg    <= S_AXI_AWID;
                  w_idx_reg   <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
                  w_len_reg   <= S_AXI_AWLEN;
                  w_cnt_reg   <= 8'd0;
                  w_err_reg   <= (S_AXI_AWBURST != 2'b01) || (S_AXI_AWSIZE != 3'b010);
                  w_state_reg <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_hs) begin
                  w_idx_reg <= w_idx_reg + IDX_ONE;
                  w_cnt_reg <= w_cnt_reg + 8'd1;
                  if (w_last_beat) begin
                     wready_reg  <= 1'b0;
                     bvalid_reg  <= 1'b1;
                     bresp_reg   <= (w_err_reg || !S_AXI_WLAST) ? 2'b10 : 2'b00;
                     w_state_reg <= W_RESP;
                  end else if (S_AXI_WLAST) begin
                     w_err_reg <= 1'b1;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  bvalid_reg  <= 1'b0;
                  awready_reg <= 1'b1;
                  w_state_reg <= W_IDLE;
               end
            end
            default: w_state_reg <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state_reg <= R_IDLE;
         arready_reg <= 1'b0;
         rvalid_reg  <= 1'b0;
         rlast_reg   <= 1'b0;
         rresp_reg   <= 2'b00;
         r_id_reg    <= 1'b0;
         r_idx_reg   <= '0;
         r_len_reg   <= 8'd0;
         r_cnt_reg   <= 8'd0;
      end else begin
         case (r_state_reg)
            R_IDLE: begin
               arready_reg <= 1'b1;
               if (S_AXI_ARVALID && arready_reg) begin
                  arready_reg <= 1'b0;
                  r_id_reg    <= S_AXI_ARID;
                  r_idx_reg   <= S_AXI_ARADDR[ADDR_WIDTH-1:2];
                  r_len_reg   <= S_AXI_ARLEN;
                  r_cnt_reg   <= 8'd0;
                  rresp_reg   <= ((S_AXI_ARBURST != 2'b01) || (S_AXI_ARSIZE != 3'b010)) ? 2'b10 : 2'b00;
                  r_state_reg <= R_FETCH;
               end
            end
            R_FETCH: begin
               rvalid_reg  <= 1'b1;
               rlast_reg   <= (r_cnt_reg == r_len_reg);
               r_state_reg <= R_DATA;
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  rvalid_reg <= 1'b0;
                  r_idx_reg  <= r_idx_reg + IDX_ONE;
                  r_cnt_reg  <= r_cnt_reg + 8'd1;
                  if (rlast_reg) begin
                     arready_reg <= 1'b1;
                     r_state_reg <= R_IDLE;
                  end else begin
                     r_state_reg <= R_FETCH;
                  end
               end
            end
            default: r_state_reg <= R_IDLE;
         endcase
      end
   end

   // One byte-wide RAM per strobe lane; the registered read in R_FETCH sees pre-write data
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] q_reg;

         always_ff @(posedge CLK) begin
            if (w_hs && S_AXI_WSTRB[gi])
               mem[w_idx_reg] <= S_AXI_WDATA[8*gi +: 8];
         end

         always_ff @(posedge CLK) begin
            if (RST)
               q_reg <= 8'h00;
            else if (r_state_reg == R_FETCH)
               q_reg <= mem[r_idx_reg];
         end

         assign rdata_w[8*gi +: 8] = q_reg;
      end
   endgenerate

   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BID     = w_id_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RID     = r_id_reg;
   assign S_AXI_RDATA   = rdata_w;
   assign S_AXI_RRESP   = rresp_reg;
   assign S_AXI_RLAST   = rlast_reg;
   assign S_AXI_RVALID  = rvalid_reg;
endmodule
